// File: rtl/load_use_stall_unit.sv
// load_use_stall_unit: load-use hazard and memory-busy pipeline stall control
// with a saturating count of cycles in which the PC is held.
module load_use_stall_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_address_id_stage,
  input  logic [4:0]  rs2_address_id_stage,
  input  logic        rs1_used_id_stage,
  input  logic        rs2_used_id_stage,
  input  logic [4:0]  destination_address_alu_stage,
  input  logic        mem_read_alu_stage,
  input  logic        data_memory_busy,
  input  logic        count_clear,
  output logic        pc_write_enable,
  output logic        if_id_write_enable,
  output logic        id_ex_write_enable,
  output logic        id_ex_bubble,
  output logic [1:0]  stall_state,
  output logic [15:0] stall_cycle_count
);
  typedef enum logic [1:0] {RUN = 2'b00, LOAD_STALL = 2'b01, MEM_WAIT = 2'b10} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_count;
  logic        w_hit;
  assign w_hit = mem_read_alu_stage && (destination_address_alu_stage != 5'd0) &&
                 ((rs1_used_id_stage && rs1_address_id_stage == destination_address_alu_stage) ||
                  (rs2_used_id_stage && rs2_address_id_stage == destination_address_alu_stage));
  // Busy outranks the hazard; LOAD_STALL masks the hit so one load gets one bubble.
  always_comb begin
    pc_write_enable    = 1'b1;
    if_id_write_enable = 1'b1;
    id_ex_write_enable = 1'b1;
    id_ex_bubble       = 1'b0;
    w_next             = RUN;
    if (!reset) begin
      w_next = RUN;
    end else if (data_memory_busy) begin
      pc_write_enable    = 1'b0;
      if_id_write_enable = 1'b0;
      id_ex_write_enable = 1'b0;
      w_next             = MEM_WAIT;
    end else if (w_hit && r_state != LOAD_STALL) begin
      pc_write_enable    = 1'b0;
      if_id_write_enable = 1'b0;
      id_ex_bubble       = 1'b1;
      w_next             = LOAD_STALL;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= RUN;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge reset)
    if (!reset)                                 r_count <= 16'd0;
    else if (count_clear)                       r_count <= 16'd0;
    else if (!pc_write_enable && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
  assign stall_state       = r_state;
  assign stall_cycle_count = r_count;
endmodule

// File: tb/tb_load_use_stall_unit.sv
// tb_load_use_stall_unit: directed and random checks of load_use_stall_unit
// against a rule-table reference model.
module tb_load_use_stall_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        u1 = 1'b0, u2 = 1'b0, mr = 1'b0, busy = 1'b0, clr = 1'b0;
  logic        pc_we, ifid_we, idex_we, bubble;
  logic [1:0]  st;
  logic [15:0] cnt;
  int checks = 0;
  int errors = 0;
  int m_state = 0;
  int m_cnt = 0;

  load_use_stall_unit dut (
    .clk(clk), .reset(reset),
    .rs1_address_id_stage(rs1), .rs2_address_id_stage(rs2),
    .rs1_used_id_stage(u1), .rs2_used_id_stage(u2),
    .destination_address_alu_stage(rd), .mem_read_alu_stage(mr),
    .data_memory_busy(busy), .count_clear(clr),
    .pc_write_enable(pc_we), .if_id_write_enable(ifid_we),
    .id_ex_write_enable(idex_we), .id_ex_bubble(bubble),
    .stall_state(st), .stall_cycle_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check mid-cycle against the model, advance model at the edge.
  task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic b1, input logic b2,
                      input logic [4:0] d, input logic m, input logic bz, input logic cl, input logic rs);
    logic hit;
    logic [3:0] e;
    int nxt;
    rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; rd = d; mr = m; busy = bz; clr = cl; reset = rs;
    if (!rs) begin m_state = 0; m_cnt = 0; end
    hit = m && d != 0 && ((b1 && a1 == d) || (b2 && a2 == d));
    if (!rs)                        begin e = 4'b1110; nxt = 0; end
    else if (bz)                    begin e = 4'b0000; nxt = 2; end
    else if (hit && m_state != 1)   begin e = 4'b0011; nxt = 1; end
    else                            begin e = 4'b1110; nxt = 0; end
    #4;
    check("pc_we",   {15'd0, pc_we},   {15'd0, e[3]});
    check("if_id_we",{15'd0, ifid_we}, {15'd0, e[2]});
    check("id_ex_we",{15'd0, idex_we}, {15'd0, e[1]});
    check("bubble",  {15'd0, bubble},  {15'd0, e[0]});
    check("state",   {14'd0, st},      m_state[15:0]);
    check("count",   cnt,              m_cnt[15:0]);
    @(posedge clk);
    if (rs) begin
      m_state = nxt;
      if (cl) m_cnt = 0;
      else if (!e[3]) m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    end
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(5, 5, 1, 1, 5, 1, 1, 0, 0);
    // Load-use on rs1: bubble, one LOAD_STALL cycle, back to RUN
    step(5, 0, 1, 0, 5, 1, 0, 0, 1);
    step(5, 0, 1, 0, 5, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("count_after_load_use", cnt, 16'd1);
    // x0 never hazards; unused rs2 never hazards
    step(0, 0, 1, 0, 0, 1, 0, 0, 1);
    step(0, 7, 1, 0, 7, 1, 0, 0, 1);
    // Three busy cycles, then release with a hit pending
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("mem_wait_state", {14'd0, st}, 16'h0002);
    step(3, 0, 1, 0, 3, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Hit and busy together: freeze first, bubble only after busy drops
    step(0, 9, 0, 1, 9, 1, 1, 0, 1);
    step(0, 9, 0, 1, 9, 1, 1, 0, 1);
    step(0, 9, 0, 1, 9, 1, 0, 0, 1);
    step(0, 9, 0, 1, 9, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Saturation: clear, then 0xFFFE stall cycles, then three more
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (65534) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("count_preload", cnt, 16'hFFFE);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("count_saturated", cnt, 16'hFFFF);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("count_clear_priority", cnt, 16'h0000);
    // Reset during MEM_WAIT aborts the freeze immediately
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("run_after_reset", {14'd0, st}, 16'h0000);
    // Random traffic with a narrow register range so hazards are frequent
    repeat (3000) begin
      logic [4:0] a1, a2, d;
      a1 = 5'($urandom_range(0, 3));
      a2 = 5'($urandom_range(0, 3));
      d  = 5'($urandom_range(0, 3));
      step(a1, a2, 1'($urandom), 1'($urandom), d, 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
